multicycle_control: RTL and testbench

Multicycle control FSM for the single-issue LEGv8 subset core. It sequences the synchronous instruction memory, register file, ALU and data memory through fetch, decode, execute, memory and writeback steps. It owns the PC, the latched instruction register and every datapath control strobe. It sits between the instruction memory output and the register-file/ALU/data-memory control inputs.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/legv8_decode.sv | 68 ++++++
 rtl/multicycle_control.sv | 156 +++++++++++++++
 tb/tb_multicycle_control.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared LEGv8 opcode, ALU, condition-code and FSM state definitions
package cpu_pkg;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_EOR = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [4:0] REG_XZR = 5'd31;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_RTYPE, CLS_LDUR, CLS_STUR, CLS_B, CLS_BCOND, CLS_HALT
  } iclass_t;

  // Carry is not consulted by any supported condition; unlisted codes fall through as not taken.
  function automatic logic cond_holds(input logic [3:0] cond, input logic n, input logic z,
                                      input logic v);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/legv8_decode.sv
// rtl/legv8_decode.sv - combinational IR decoder: class, ALU op, register fields, immediate, branch offset
module legv8_decode
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic [31:0]       ir,
  output logic [2:0]        iclass,
  output logic [2:0]        alu_op,
  output logic [4:0]        rn,
  output logic [4:0]        rm,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] data_imm,
  output logic [ADDR_W-1:0] br_off,
  output logic [3:0]        cond
);

  always_comb begin
    iclass = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    if (ir == 32'h0) begin
      iclass = CLS_HALT;
    end else if (ir[31:26] == OP_B) begin
      iclass = CLS_B;
    end else if (ir[31:24] == OP_BCOND) begin
      iclass = CLS_BCOND;
    end else begin
      case (ir[31:21])
        OP_LDUR: iclass = CLS_LDUR;
        OP_STUR: iclass = CLS_STUR;
        OP_ADD: begin
          iclass = CLS_RTYPE;
          alu_op = ALU_ADD;
        end
        OP_SUB: begin
          iclass = CLS_RTYPE;
          alu_op = ALU_SUB;
        end
        OP_EOR: begin
          iclass = CLS_RTYPE;
          alu_op = ALU_EOR;
        end
        OP_ORR: begin
          iclass = CLS_RTYPE;
          alu_op = ALU_ORR;
        end
        default: iclass = CLS_ILLEGAL;
      endcase
    end
  end

  assign rn       = ir[9:5];
  assign rd       = ir[4:0];
  assign rm       = (iclass == CLS_STUR) ? ir[4:0] : ir[20:16];
  assign cond     = ir[3:0];
  assign data_imm = {{(DATA_W-9){ir[20]}}, ir[20:12]};

  // PC arithmetic is modulo 2^ADDR_W, so only the low bits of the sign-extended offset matter.
  always_comb begin
    if (iclass == CLS_B) begin
      br_off = ADDR_W'(ir[25:0]);
    end else begin
      br_off = ADDR_W'({{7{ir[23]}}, ir[23:5]});
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle LEGv8 control FSM owning PC, IR and all datapath strobes
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [31:0]       Instr,
  input  logic              FlagN,
  input  logic              FlagZ,
  input  logic              FlagC,
  input  logic              FlagV,
  input  logic              MemAck,
  output logic [ADDR_W-1:0] PC,
  output logic [4:0]        ReadAddr1,
  output logic [4:0]        ReadAddr2,
  output logic [4:0]        WriteAddr,
  output logic              RegWrEn,
  output logic [2:0]        ALUOp,
  output logic              ALUSrc,
  output logic [DATA_W-1:0] DataImm,
  output logic              MemReq,
  output logic              MemWrite,
  output logic              MemToReg,
  output logic              Done,
  output logic              Illegal
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              illegal_q, illegal_d;

  logic [2:0]        iclass;
  logic [2:0]        alu_op;
  logic [4:0]        rn, rm, rd;
  logic [DATA_W-1:0] data_imm;
  logic [ADDR_W-1:0] br_off;
  logic [3:0]        cond;
  logic              is_ldur, is_stur;
  logic              flag_c_unused;

  assign flag_c_unused = FlagC;

  legv8_decode #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_decode (
    .ir      (ir_q),
    .iclass  (iclass),
    .alu_op  (alu_op),
    .rn      (rn),
    .rm      (rm),
    .rd      (rd),
    .data_imm(data_imm),
    .br_off  (br_off),
    .cond    (cond)
  );

  assign is_ldur = (iclass == CLS_LDUR);
  assign is_stur = (iclass == CLS_STUR);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = FETCH;
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        ir_d    = Instr;
        state_d = (Instr == 32'h0) ? HALT : EXEC;
      end
      EXEC: begin
        case (iclass)
          CLS_RTYPE: state_d = WB;
          CLS_LDUR, CLS_STUR: state_d = MEM;
          CLS_B: begin
            pc_d    = pc_q + br_off;
            state_d = FETCH;
          end
          CLS_BCOND: begin
            pc_d    = cond_holds(cond, FlagN, FlagZ, FlagV) ? pc_q + br_off : pc_q + PC_ONE;
            state_d = FETCH;
          end
          default: begin
            // Undecodable words are flagged and skipped rather than halting the core.
            illegal_d = 1'b1;
            pc_d      = pc_q + PC_ONE;
            state_d   = FETCH;
          end
        endcase
      end
      MEM: begin
        if (MemAck) begin
          if (is_ldur) begin
            state_d = WB;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        pc_d    = pc_q + PC_ONE;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every control output depends only on registered state and IR.
  assign PC        = pc_q;
  assign ReadAddr1 = rn;
  assign ReadAddr2 = rm;
  assign WriteAddr = rd;
  assign ALUOp     = alu_op;
  assign ALUSrc    = is_ldur || is_stur;
  assign DataImm   = data_imm;
  assign MemReq    = (state_q == MEM);
  assign MemWrite  = (state_q == MEM) && is_stur;
  assign MemToReg  = (state_q == WB) && is_ldur;
  assign RegWrEn   = (state_q == WB) && (rd != REG_XZR);
  assign Done      = (state_q == HALT);
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              Clock = 1'b0;
  logic              Reset, Start;
  logic [31:0]       Instr;
  logic              FlagN, FlagZ, FlagC, FlagV, MemAck;
  logic [ADDR_W-1:0] PC;
  logic [4:0]        ReadAddr1, ReadAddr2, WriteAddr;
  logic              RegWrEn, ALUSrc, MemReq, MemWrite, MemToReg, Done, Illegal;
  logic [2:0]        ALUOp;
  logic [DATA_W-1:0] DataImm;

  always #5 Clock = ~Clock;

  multicycle_control #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Instr(Instr),
    .FlagN(FlagN), .FlagZ(FlagZ), .FlagC(FlagC), .FlagV(FlagV), .MemAck(MemAck),
    .PC(PC), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .WriteAddr(WriteAddr),
    .RegWrEn(RegWrEn), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .DataImm(DataImm),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .Done(Done), .Illegal(Illegal)
  );

  // Synchronous instruction memory: data for PC appears one cycle later.
  logic [31:0] imem [0:31];
  always @(posedge Clock) Instr <= imem[PC];

  // Data memory responder: ack in the ack_delay-th MEM cycle, or permanently high.
  int   ack_delay;
  logic ack_always;
  int   mem_cnt;
  always @(negedge Clock) begin
    if (ack_always) begin
      MemAck  <= 1'b1;
      mem_cnt <= 0;
    end else if (MemReq) begin
      mem_cnt <= mem_cnt + 1;
      MemAck  <= ((mem_cnt + 1) == ack_delay);
    end else begin
      mem_cnt <= 0;
      MemAck  <= 1'b0;
    end
  end

  typedef struct {
    logic [4:0]  addr;
    logic        m2r;
    logic [2:0]  alu;
    logic        alusrc;
    int          cyc;
    logic        imm_chk;
    logic [31:0] imm;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  nzcv;
    int          ack;
    logic [4:0]  exp_pc;
    logic        exp_wr;
    logic [4:0]  exp_rd;
    logic        exp_m2r;
    logic [2:0]  exp_alu;
    int          exp_wr_cyc;
    int          exp_cycles;
    int          exp_memreq;
    logic        exp_memwr;
    logic        exp_ill;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 32; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Start from IDLE, walk negedges until Done, scoring each register write against exp_q.
  task automatic run_prog(input string tag, input int budget, output int cycles,
                          output int memreq_n, output logic memwr_seen);
    int cyc;
    cyc = 1;
    memreq_n = 0;
    memwr_seen = 1'b0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk({tag, "_fetch_pc"}, 32'(PC), 32'h0);
    while (!Done) begin
      if (RegWrEn) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_unexpected_regwr: got write to X%0d at cycle %0d, want none",
                   tag, WriteAddr, cyc);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk({tag, "_wr_addr"}, 32'(WriteAddr), 32'(e.addr));
          chk({tag, "_wr_memtoreg"}, 32'(MemToReg), 32'(e.m2r));
          chk({tag, "_wr_aluop"}, 32'(ALUOp), 32'(e.alu));
          chk({tag, "_wr_alusrc"}, 32'(ALUSrc), 32'(e.alusrc));
          chk({tag, "_wr_cycle"}, 32'(cyc), 32'(e.cyc));
          if (e.imm_chk) chk({tag, "_dataimm"}, DataImm, e.imm);
        end
      end
      if (MemReq) memreq_n++;
      if (MemWrite) memwr_seen = 1'b1;
      if (cyc >= budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: got no Done after %0d cycles, want Done", tag, cyc);
        break;
      end
      cyc++;
      @(negedge Clock);
    end
    cycles = cyc - 1;
    chk({tag, "_pending_wr"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    int cycles, memreq_n, wr_n, mr_n, pc_n, w;
    logic memwr_seen;

    Reset = 1'b1; Start = 1'b0;
    FlagN = 1'b0; FlagZ = 1'b0; FlagC = 1'b0; FlagV = 1'b0;
    ack_always = 1'b0; ack_delay = 1;
    clr_imem();

    // Reset state and idling without Start
    do_reset();
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_regwren", 32'(RegWrEn), 32'h0);
    chk("rst_memreq", 32'(MemReq), 32'h0);
    chk("rst_memwrite", 32'(MemWrite), 32'h0);
    chk("rst_memtoreg", 32'(MemToReg), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_illegal", 32'(Illegal), 32'h0);
    repeat (3) @(negedge Clock);
    chk("idle_pc", 32'(PC), 32'h0);
    chk("idle_memreq", 32'(MemReq), 32'h0);

    //                name       instr          nzcv     ack pc     wr  rd     m2r alu     wcy cyc mrq mw ill
    vq.push_back(vec_t'{"add",    32'h8B020023, 4'b0000, 1, 5'd1,  1, 5'd3,  0, 3'b000, 4, 6, 0, 0, 0});
    vq.push_back(vec_t'{"sub",    32'hCB020025, 4'b0000, 1, 5'd1,  1, 5'd5,  0, 3'b001, 4, 6, 0, 0, 0});
    vq.push_back(vec_t'{"eor",    32'hCA020027, 4'b0000, 1, 5'd1,  1, 5'd7,  0, 3'b010, 4, 6, 0, 0, 0});
    vq.push_back(vec_t'{"orr",    32'hAA020029, 4'b0000, 1, 5'd1,  1, 5'd9,  0, 3'b011, 4, 6, 0, 0, 0});
    vq.push_back(vec_t'{"add_xzr",32'h8B02003F, 4'b0000, 1, 5'd1,  0, 5'd31, 0, 3'b000, 0, 6, 0, 0, 0});
    vq.push_back(vec_t'{"ldur",   32'hF85F8024, 4'b0000, 3, 5'd1,  1, 5'd4,  1, 3'b000, 7, 9, 3, 0, 0});
    vq.push_back(vec_t'{"stur",   32'hF8000046, 4'b0000, 2, 5'd1,  0, 5'd6,  0, 3'b000, 0, 7, 2, 1, 0});
    vq.push_back(vec_t'{"b_m1",   32'h17FFFFFF, 4'b0000, 1, 5'd31, 0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 0});
    vq.push_back(vec_t'{"b_p5",   32'h14000005, 4'b0000, 1, 5'd5,  0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 0});
    vq.push_back(vec_t'{"beq_nt", 32'h54000080, 4'b0000, 1, 5'd1,  0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 0});
    vq.push_back(vec_t'{"beq_t",  32'h54000080, 4'b0100, 1, 5'd4,  0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 0});
    vq.push_back(vec_t'{"blt_t",  32'h5400004B, 4'b1000, 1, 5'd2,  0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 0});
    vq.push_back(vec_t'{"bgt_nt", 32'h5400008C, 4'b0100, 1, 5'd1,  0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 0});
    vq.push_back(vec_t'{"bal_m2", 32'h54FFFFCE, 4'b0000, 1, 5'd30, 0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 0});
    vq.push_back(vec_t'{"illegal",32'hFFFFFFFF, 4'b0000, 1, 5'd1,  0, 5'd0,  0, 3'b000, 0, 5, 0, 0, 1});

    foreach (vq[i]) begin
      do_reset();
      clr_imem();
      imem[0] = vq[i].instr;
      {FlagN, FlagZ, FlagC, FlagV} = vq[i].nzcv;
      ack_always = 1'b0;
      ack_delay = vq[i].ack;
      if (vq[i].exp_wr) begin
        exp_q.push_back(wr_t'{vq[i].exp_rd, vq[i].exp_m2r, vq[i].exp_alu, vq[i].exp_m2r,
                              vq[i].exp_wr_cyc, vq[i].exp_m2r, 32'hFFFFFFF8});
      end
      run_prog(vq[i].name, 40, cycles, memreq_n, memwr_seen);
      chk({vq[i].name, "_pc"}, 32'(PC), 32'(vq[i].exp_pc));
      chk({vq[i].name, "_illegal"}, 32'(Illegal), 32'(vq[i].exp_ill));
      chk({vq[i].name, "_cycles"}, 32'(cycles), 32'(vq[i].exp_cycles));
      chk({vq[i].name, "_memreq_cycles"}, 32'(memreq_n), 32'(vq[i].exp_memreq));
      chk({vq[i].name, "_memwrite"}, 32'(memwr_seen), 32'(vq[i].exp_memwr));
    end
    {FlagN, FlagZ, FlagC, FlagV} = 4'b0000;

    // Reset while an LDUR waits for its ack
    do_reset();
    clr_imem();
    imem[0] = 32'hF85F8024;
    ack_always = 1'b0;
    ack_delay = 1000;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    w = 0;
    while (!MemReq && w < 10) begin
      @(negedge Clock);
      w++;
    end
    chk("abort_memreq_seen", 32'(MemReq), 32'h1);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_memreq", 32'(MemReq), 32'h0);
    chk("abort_pc", 32'(PC), 32'h0);
    chk("abort_regwren", 32'(RegWrEn), 32'h0);
    chk("abort_done", 32'(Done), 32'h0);
    Reset = 1'b0;
    wr_n = 0; mr_n = 0; pc_n = 0;
    repeat (8) begin
      @(negedge Clock);
      if (RegWrEn) wr_n++;
      if (MemReq) mr_n++;
      if (PC != 5'd0) pc_n++;
    end
    chk("abort_idle_writes", 32'(wr_n), 32'h0);
    chk("abort_idle_memreq", 32'(mr_n), 32'h0);
    chk("abort_idle_pc_moves", 32'(pc_n), 32'h0);

    // Start and Reset together: Reset wins and the core stays idle
    clr_imem();
    imem[0] = 32'h8B020023;
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    Start = 1'b0;
    wr_n = 0; pc_n = 0;
    repeat (8) begin
      @(negedge Clock);
      if (RegWrEn) wr_n++;
      if (PC != 5'd0) pc_n++;
    end
    chk("rststart_writes", 32'(wr_n), 32'h0);
    chk("rststart_pc_moves", 32'(pc_n), 32'h0);
    exp_q.push_back(wr_t'{5'd3, 1'b0, 3'b000, 1'b0, 4, 1'b0, 32'h0});
    run_prog("rststart_then_add", 40, cycles, memreq_n, memwr_seen);
    chk("rststart_then_add_pc", 32'(PC), 32'h1);

    // Three-instruction program with MemAck held high throughout
    do_reset();
    clr_imem();
    imem[0] = 32'h8B020023;
    imem[1] = 32'hF8000046;
    imem[2] = 32'hCB020025;
    ack_always = 1'b1;
    exp_q.push_back(wr_t'{5'd3, 1'b0, 3'b000, 1'b0, 4, 1'b0, 32'h0});
    exp_q.push_back(wr_t'{5'd5, 1'b0, 3'b001, 1'b0, 12, 1'b0, 32'h0});
    run_prog("prog", 60, cycles, memreq_n, memwr_seen);
    chk("prog_pc", 32'(PC), 32'h3);
    chk("prog_cycles", 32'(cycles), 32'd14);
    chk("prog_memreq_cycles", 32'(memreq_n), 32'h1);
    chk("prog_memwrite", 32'(memwr_seen), 32'h1);

    // Start in HALT is ignored
    Start = 1'b1;
    repeat (2) @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    chk("halt_done", 32'(Done), 32'h1);
    chk("halt_pc", 32'(PC), 32'h3);
    chk("halt_memreq", 32'(MemReq), 32'h0);
    chk("halt_regwren", 32'(RegWrEn), 32'h0);
    ack_always = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
